// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers 640x480@60 style VGA timing from incoming
// hsync/vsync and 1-bit RGB. Measures line and frame length, locks after
// LOCK_FRAMES consecutive good frames, then emits pixel coordinates,
// data-enable and pixel data.
// Pipeline: stage 1 registers the inputs, stage 2 holds the counters and
// the FSM, stage 3 holds the registered outputs. A sample captured at edge n
// reaches the outputs after edge n+2.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_red,
  input  logic        i_grn,
  input  logic        i_blu,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_de,
  output logic        o_red,
  output logic        o_grn,
  output logic        o_blu,
  output logic        o_frame_start,
  output logic        o_locked,
  output logic        o_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_TOT12   = 12'(H_TOTAL);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_TOT12   = 12'(V_TOTAL);
  localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] CNT_MAX   = 12'hFFF;
  localparam logic [3:0]  GOOD_GOAL = 4'(LOCK_FRAMES);
  localparam logic        SYNC_LVL  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Stage 1 registers
  logic s_hsync_q, s_vsync_q, s_hsync_dly_q, s_vsync_dly_q;
  logic s_red_q, s_grn_q, s_blu_q;

  // Stage 2 registers
  logic [11:0] hcnt_q, vcnt_q;
  logic [11:0] hcnt_d, vcnt_d;
  state_e      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        err_q;
  logic        p_red_q, p_grn_q, p_blu_q;

  // Stage 3 (output) registers
  logic [11:0] x_q, y_q;
  logic        de_q, red_q, grn_q, blu_q, fs_q, locked_q, oerr_q;

  // Combinational helpers
  logic        hs_edge_s, vs_edge_s;
  logic [11:0] hcnt_inc_s, vcnt_inc_s;
  logic        short_line_s, long_line_s, frame_len_s, misalign_s, viol_s;
  logic        active_s;
  logic [11:0] x_s, y_s;

  // Stage 1: register the raw inputs plus a delayed copy of the syncs; idle syncs after reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_hsync_q     <= ~SYNC_LVL;
      s_vsync_q     <= ~SYNC_LVL;
      s_hsync_dly_q <= ~SYNC_LVL;
      s_vsync_dly_q <= ~SYNC_LVL;
      s_red_q       <= 1'b0;
      s_grn_q       <= 1'b0;
      s_blu_q       <= 1'b0;
    end else begin
      s_hsync_q     <= i_hsync;
      s_vsync_q     <= i_vsync;
      s_hsync_dly_q <= s_hsync_q;
      s_vsync_dly_q <= s_vsync_q;
      s_red_q       <= i_red;
      s_grn_q       <= i_grn;
      s_blu_q       <= i_blu;
    end
  end

  // Sync edge detection, saturating counter updates and timing-violation checks
  always_comb begin
    hs_edge_s  = (s_hsync_q == SYNC_LVL) && (s_hsync_dly_q != SYNC_LVL);
    vs_edge_s  = (s_vsync_q == SYNC_LVL) && (s_vsync_dly_q != SYNC_LVL);
    hcnt_inc_s = (hcnt_q == CNT_MAX) ? CNT_MAX : (hcnt_q + 12'd1);
    vcnt_inc_s = (vcnt_q == CNT_MAX) ? CNT_MAX : (vcnt_q + 12'd1);

    if (hs_edge_s) begin
      hcnt_d = 12'd0;
    end else begin
      hcnt_d = hcnt_inc_s;
    end

    // vsync restart wins over the per-line increment
    if (vs_edge_s) begin
      vcnt_d = 12'd0;
    end else if (hs_edge_s) begin
      vcnt_d = vcnt_inc_s;
    end else begin
      vcnt_d = vcnt_q;
    end

    short_line_s = hs_edge_s && (hcnt_q != H_LAST);
    long_line_s  = !hs_edge_s && (hcnt_inc_s == H_TOT12);
    frame_len_s  = (vs_edge_s && (vcnt_q != V_LAST)) ||
                   (!vs_edge_s && hs_edge_s && (vcnt_inc_s == V_TOT12));
    misalign_s   = vs_edge_s && !hs_edge_s;
    viol_s       = (state_q != ST_SEARCH) &&
                   (short_line_s || long_line_s || frame_len_s || misalign_s);
  end

  // Lock FSM next state and good-frame counting
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_SEARCH: begin
        good_d = 4'd0;
        if (vs_edge_s && hs_edge_s) begin
          state_d = ST_VERIFY;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_VERIFY: begin
        if (viol_s) begin
          state_d = ST_SEARCH;
          good_d  = 4'd0;
        end else if (vs_edge_s) begin
          good_d = good_q + 4'd1;
          if ((good_q + 4'd1) == GOOD_GOAL) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_VERIFY;
          end
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (viol_s) begin
          state_d = ST_SEARCH;
          good_d  = 4'd0;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = 4'd0;
      end
    endcase
  end

  // Stage 2: counters, FSM state, violation flag and pixel data aligned with the counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcnt_q  <= 12'd0;
      vcnt_q  <= 12'd0;
      state_q <= ST_SEARCH;
      good_q  <= 4'd0;
      err_q   <= 1'b0;
      p_red_q <= 1'b0;
      p_grn_q <= 1'b0;
      p_blu_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      state_q <= state_d;
      good_q  <= good_d;
      err_q   <= viol_s;
      p_red_q <= s_red_q;
      p_grn_q <= s_grn_q;
      p_blu_q <= s_blu_q;
    end
  end

  // Active-area decode and coordinate translation for the output stage
  always_comb begin
    active_s = (state_q == ST_LOCKED) &&
               (hcnt_q >= H_ACT_LO) && (hcnt_q < H_ACT_HI) &&
               (vcnt_q >= V_ACT_LO) && (vcnt_q < V_ACT_HI);
    if (active_s) begin
      x_s = hcnt_q - H_ACT_LO;
      y_s = vcnt_q - V_ACT_LO;
    end else begin
      x_s = 12'd0;
      y_s = 12'd0;
    end
  end

  // Stage 3: registered outputs; data and coordinates forced to zero outside the active area
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q      <= 12'd0;
      y_q      <= 12'd0;
      de_q     <= 1'b0;
      red_q    <= 1'b0;
      grn_q    <= 1'b0;
      blu_q    <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      x_q      <= x_s;
      y_q      <= y_s;
      de_q     <= active_s;
      red_q    <= active_s && p_red_q;
      grn_q    <= active_s && p_grn_q;
      blu_q    <= active_s && p_blu_q;
      fs_q     <= active_s && (x_s == 12'd0) && (y_s == 12'd0);
      locked_q <= (state_q == ST_LOCKED);
      oerr_q   <= err_q;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_de          = de_q;
  assign o_red         = red_q;
  assign o_grn         = grn_q;
  assign o_blu         = blu_q;
  assign o_frame_start = fs_q;
  assign o_locked      = locked_q;
  assign o_err         = oerr_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced 16x11 timing so whole frames
// are cheap. Two instances run in parallel: active-low syncs and active-high
// (inverted) syncs, both compared against one behavioural reference model.
module tb_vga_sync_decoder;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hs0, vs0, hs1, vs1, rin, gin, bin;
  logic [11:0] x0, y0, x1, y1;
  logic de0, r0, g0, b0, fs0, lk0, er0;
  logic de1, r1, g1, b1, fs1, lk1, er1;

  vga_sync_decoder #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(0), .LOCK_FRAMES(LF)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs0), .i_vsync(vs0),
    .i_red(rin), .i_grn(gin), .i_blu(bin),
    .o_x(x0), .o_y(y0), .o_de(de0), .o_red(r0), .o_grn(g0), .o_blu(b0),
    .o_frame_start(fs0), .o_locked(lk0), .o_err(er0));

  vga_sync_decoder #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(1), .LOCK_FRAMES(LF)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs1), .i_vsync(vs1),
    .i_red(rin), .i_grn(gin), .i_blu(bin),
    .o_x(x1), .o_y(y1), .o_de(de1), .o_red(r1), .o_grn(g1), .o_blu(b1),
    .o_frame_start(fs1), .o_locked(lk1), .o_err(er1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state (positions measured in samples since sync edges)
  int m_state;       // 0 search, 1 verify, 2 locked
  int m_good;
  bit m_prev_hs, m_prev_vs;
  int m_t, m_last_hs, m_v;
  logic [30:0] q[$];

  // observation bookkeeping
  int lock_cyc, fs_cyc, cnt_de, cnt_fs, cnt_err, cnt_lock, run, runs, run_bad;
  logic [2:0] corner_rgb;

  function automatic logic [30:0] pack(logic [11:0] x, logic [11:0] y, logic de,
                                       logic r, logic g, logic b, logic fs,
                                       logic lk, logic er);
    return {x, y, de, r, g, b, fs, lk, er};
  endfunction

  task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_good    = 0;
    m_prev_hs = 1'b0;
    m_prev_vs = 1'b0;
    m_last_hs = m_t;
    m_v       = 0;
  endtask

  // Behavioural model: expected outputs for one stream sample (hs/vs = sync active)
  task automatic model(input bit hs, input bit vs, input bit r, input bit g,
                       input bit b, output logic [30:0] e);
    bit hs_e, vs_e, viol, de, lk;
    int line_len, h, old_v, x, y;
    hs_e = hs && !m_prev_hs;
    vs_e = vs && !m_prev_vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    m_t++;
    line_len = m_t - m_last_hs;
    if (hs_e) m_last_hs = m_t;
    h = m_t - m_last_hs;
    old_v = m_v;
    if (vs_e) m_v = 0;
    else if (hs_e) m_v++;
    viol = (m_state != 0) &&
           ((hs_e && line_len != HT) ||
            (!hs_e && h == HT) ||
            (vs_e && old_v != VT - 1) ||
            (hs_e && !vs_e && m_v == VT) ||
            (vs_e && !hs_e));
    if (m_state == 0) begin
      if (vs_e && hs_e) begin m_state = 1; m_good = 0; end
    end else if (viol) begin
      m_state = 0; m_good = 0;
    end else if (m_state == 1 && vs_e) begin
      m_good++;
      if (m_good == LF) m_state = 2;
    end
    lk = (m_state == 2);
    de = lk && (h >= HS + HB) && (h < HS + HB + HA) &&
         (m_v >= VS + VB) && (m_v < VS + VB + VA);
    x = de ? h - (HS + HB) : 0;
    y = de ? m_v - (VS + VB) : 0;
    e = pack(12'(x), 12'(y), de, de & r, de & g, de & b,
             de && x == 0 && y == 0, lk, viol);
  endtask

  // One clock of stimulus followed by checking both instances
  task automatic step(input bit hs_a, input bit vs_a, input bit r, input bit g,
                      input bit b, input bit rst_i);
    logic [30:0] e, o0, o1;
    rst = rst_i;
    hs0 = hs_a ? 1'b0 : 1'b1;
    vs0 = vs_a ? 1'b0 : 1'b1;
    hs1 = ~hs0;
    vs1 = ~vs0;
    rin = r; gin = g; bin = b;
    @(posedge clk);
    #1;
    cyc++;
    o0 = pack(x0, y0, de0, r0, g0, b0, fs0, lk0, er0);
    o1 = pack(x1, y1, de1, r1, g1, b1, fs1, lk1, er1);
    if (rst_i) begin
      chk("reset_lo", o0, 31'd0);
      chk("reset_hi", o1, 31'd0);
      model_reset();
      q.delete();
      q.push_back(31'd0);
      q.push_back(31'd0);
    end else begin
      model(hs_a, vs_a, r, g, b, e);
      q.push_back(e);
      e = q.pop_front();
      chk("stream_lo", o0, e);
      chk("stream_hi", o1, e);
    end
    if (lk0 && lock_cyc < 0) lock_cyc = cyc;
    if (fs0 && fs_cyc < 0) fs_cyc = cyc;
    if (de0) cnt_de++;
    if (fs0) cnt_fs++;
    if (er0) cnt_err++;
    if (lk0) cnt_lock++;
    if (de0 && x0 == 12'(HA - 1) && y0 == 12'(VA - 1)) corner_rgb = {r0, g0, b0};
    if (de0) begin
      run++;
    end else if (run > 0) begin
      runs++;
      if (run != HA) run_bad++;
      run = 0;
    end
  endtask

  task automatic clear_counts();
    cnt_de = 0; cnt_fs = 0; cnt_err = 0; cnt_lock = 0;
    run = 0; runs = 0; run_bad = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // One frame; optional short line, mid-frame reset, missing vsync, shifted vsync, gradient data
  task automatic frame(input int short_line, input int rst_line, input bit no_vs,
                       input int vs_shift, input bit grad);
    int len, p, x, y;
    bit hs_a, vs_a, rr, gg, bb, rs;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        hs_a = (h < HS);
        p = l * HT + h;
        if (vs_shift == 0) vs_a = (l < VS);
        else vs_a = (((p + FRAME - vs_shift) % FRAME) < VS * HT);
        if (no_vs) vs_a = 1'b0;
        rs = (l == rst_line) && (h >= 5) && (h < 8);
        if (grad) begin
          x = h - (HS + HB);
          y = l - (VS + VB);
          rr = x[0]; gg = y[0]; bb = x[2];
        end else begin
          rr = 1'($urandom); gg = 1'($urandom); bb = 1'($urandom);
        end
        step(hs_a, vs_a, rr, gg, bb, rs);
      end
    end
  endtask

  initial begin
    int t_edge, cx, cy;
    logic [2:0] exp_corner;
    m_t = 0;
    lock_cyc = -1;
    fs_cyc = -1;
    corner_rgb = 3'b000;
    clear_counts();
    model_reset();

    // reset, then idle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(5);

    // lock acquisition on an ideal stream
    lock_cyc = -1;
    fs_cyc = -1;
    t_edge = cyc + 1;
    for (int f = 0; f < 3; f++) frame(-1, -1, 1'b0, 0, 1'b0);
    chk_int("lock_latency", lock_cyc - t_edge, LF * FRAME + 2);
    chk_int("first_frame_start", fs_cyc - lock_cyc, (VS + VB) * HT + HS + HB);

    // gradient frame while locked: run lengths, counts, corner pixel
    clear_counts();
    frame(-1, -1, 1'b0, 0, 1'b1);
    chk_int("de_total", cnt_de, HA * VA);
    chk_int("de_runs", runs, VA);
    chk_int("de_run_len_bad", run_bad, 0);
    chk_int("frame_start_cnt", cnt_fs, 1);
    chk_int("err_when_clean", cnt_err, 0);
    cx = HA - 1;
    cy = VA - 1;
    exp_corner = {cx[0], cy[0], cx[2]};
    chk_int("corner_rgb", int'(corner_rgb), int'(exp_corner));

    // short line while locked, then relock
    clear_counts();
    frame(int'($urandom_range(VT - 1, 2)), -1, 1'b0, 0, 1'b0);
    chk_int("short_line_err", cnt_err, 1);
    for (int f = 0; f < 3; f++) frame(-1, -1, 1'b0, 0, 1'b0);
    chk_int("relock_after_short", int'(lk0), 1);

    // lost vsync: frame length error, then relock
    clear_counts();
    frame(-1, -1, 1'b1, 0, 1'b0);
    chk_int("long_frame_err", cnt_err, 1);
    for (int f = 0; f < 3; f++) frame(-1, -1, 1'b0, 0, 1'b0);
    chk_int("relock_after_long_frame", int'(lk0), 1);

    // hsync held idle: long line error, then relock
    clear_counts();
    idle(HT + 10);
    chk_int("long_line_err", cnt_err, 1);
    for (int f = 0; f < 3; f++) frame(-1, -1, 1'b0, 0, 1'b0);
    chk_int("relock_after_long_line", int'(lk0), 1);

    // mid-frame reset while locked, then relock
    frame(-1, int'($urandom_range(8, 3)), 1'b0, 0, 1'b0);
    for (int f = 0; f < 3; f++) frame(-1, -1, 1'b0, 0, 1'b0);
    chk_int("relock_after_reset", int'(lk0), 1);

    // misaligned vsync from reset: never locks, no errors while searching
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clear_counts();
    for (int f = 0; f < 3; f++) frame(-1, -1, 1'b0, 3, 1'b0);
    chk_int("misalign_lock", cnt_lock, 0);
    chk_int("misalign_err", cnt_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
